mux_2to1_rr_stage: RTL and testbench



---
 rtl/mux_2to1_rr_stage_pkg.sv | 15 +
 rtl/mux_2to1_rr_stage_mux.sv | 16 +
 rtl/mux_2to1_rr_stage.sv | 93 +++++++++
 tb/tb_mux_2to1_rr_stage.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mux_2to1_rr_stage_pkg.sv
// Shared constants and types for the round-robin 2:1 mux front end.
package mux_2to1_rr_stage_pkg;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int DEF_W  = 4;
    localparam int DEF_CW = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ostate_t;

endpackage

// File: rtl/mux_2to1_rr_stage_mux.sv
// Behavioural if-style 2:1 data mux; sel = 1 picks b.
module mux_2to1_4bit_b_if #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sel,
    output logic [W-1:0] y
);

    always_comb begin
        if (sel) y = b;
        else     y = a;
    end

endmodule

// File: rtl/mux_2to1_rr_stage.sv
// Round-robin arbiter for two valid/ready channels feeding a one-deep output register.
// state | meaning
// EMPTY | output register holds no unconsumed word
// FULL  | out holds a word waiting for out_ready
module mux_2to1_rr_stage
    import mux_2to1_rr_stage_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  a,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [W-1:0]  b,
    input  logic          b_valid,
    output logic          b_ready,
    output logic          sel,
    output logic [W-1:0]  out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] cnt_a,
    output logic [CW-1:0] cnt_b
);

    ostate_t       state_q, state_d;
    logic          last_q;
    logic          load_en;
    logic          accept;
    logic [W-1:0]  mux_y;
    logic [W-1:0]  out_q;
    logic [CW-1:0] cnt_a_q, cnt_b_q;

    assign load_en = (state_q == EMPTY) || out_ready;
    assign accept  = load_en && (a_valid || b_valid);

    // last resets to B so that A wins the first tie
    always_comb begin
        sel = SEL_A;
        if (a_valid && b_valid) sel = ~last_q;
        else if (b_valid)       sel = SEL_B;
    end

    mux_2to1_4bit_b_if #(.W(W)) u_mux (
        .a   (a),
        .b   (b),
        .sel (sel),
        .y   (mux_y)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL: begin
                if (accept)         state_d = FULL;
                else if (out_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q == FULL);
        a_ready   = accept && (sel == SEL_A);
        b_ready   = accept && (sel == SEL_B);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= '0;
            last_q  <= SEL_B;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else if (accept) begin
            out_q  <= mux_y;
            last_q <= sel;
            if (sel == SEL_B) cnt_b_q <= cnt_b_q + CW'(1);
            else              cnt_a_q <= cnt_a_q + CW'(1);
        end
    end

    assign out   = out_q;
    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;

endmodule

// File: tb/tb_mux_2to1_rr_stage.sv
// Directed bench for mux_2to1_rr_stage; a second instance with 2-bit counters covers wrap.
module tb_mux_2to1_rr_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] a, b;
    logic       a_valid, b_valid, out_ready;

    logic       a_ready, b_ready, sel, out_valid;
    logic [3:0] out_w;
    logic [7:0] cnt_a, cnt_b;

    logic       a_ready2, b_ready2, sel2, out_valid2;
    logic [3:0] out2;
    logic [1:0] cnt_a2, cnt_b2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux_2to1_rr_stage #(.W(4), .CW(8)) dut (
        .clk(clk), .reset(reset),
        .a(a), .a_valid(a_valid), .a_ready(a_ready),
        .b(b), .b_valid(b_valid), .b_ready(b_ready),
        .sel(sel), .out(out_w), .out_valid(out_valid), .out_ready(out_ready),
        .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    mux_2to1_rr_stage #(.W(4), .CW(2)) dut2 (
        .clk(clk), .reset(reset),
        .a(a), .a_valid(a_valid), .a_ready(a_ready2),
        .b(b), .b_valid(b_valid), .b_ready(b_ready2),
        .sel(sel2), .out(out2), .out_valid(out_valid2), .out_ready(out_ready),
        .cnt_a(cnt_a2), .cnt_b(cnt_b2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; a = 4'h0; b = 4'h0;
        a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        checks++; if (out_w !== 4'h0)     begin errors++; $display("FAIL reset_out got=%h exp=0", out_w); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (cnt_a !== 8'd0 || cnt_b !== 8'd0)
            begin errors++; $display("FAIL reset_cnt got a=%0d b=%0d exp 0 0", cnt_a, cnt_b); end
        checks++; if (sel !== 1'b0)       begin errors++; $display("FAIL reset_sel got=%b exp=0", sel); end
    endtask

    task automatic test_solo_a();
        logic [3:0] vals [3];
        vals[0] = 4'd2; vals[1] = 4'd3; vals[2] = 4'd4;
        for (int i = 0; i < 3; i++) begin
            a = vals[i]; a_valid = 1'b1; b_valid = 1'b0; out_ready = 1'b1;
            #1;
            checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0)
                begin errors++; $display("FAIL solo_ready[%0d] got a=%b b=%b exp a=1 b=0", i, a_ready, b_ready); end
            tick();
            checks++; if (out_w !== vals[i] || out_valid !== 1'b1)
                begin errors++; $display("FAIL solo_out[%0d] got=%h v=%b exp=%h v=1", i, out_w, out_valid, vals[i]); end
        end
        a_valid = 1'b0;
        checks++; if (cnt_a !== 8'd3 || cnt_b !== 8'd0)
            begin errors++; $display("FAIL solo_cnt got a=%0d b=%0d exp 3 0", cnt_a, cnt_b); end
    endtask

    task automatic test_contention();
        logic [3:0] exp_out [4];
        exp_out[0] = 4'h5; exp_out[1] = 4'hC; exp_out[2] = 4'h5; exp_out[3] = 4'hC;
        reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        tick();
        reset = 1'b0;
        a = 4'h5; b = 4'hC; a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (sel !== 1'(i % 2) || (a_ready && b_ready))
                begin errors++; $display("FAIL cont_sel[%0d] got sel=%b ar=%b br=%b exp sel=%0d", i, sel, a_ready, b_ready, i % 2); end
            tick();
            checks++; if (out_w !== exp_out[i] || out_valid !== 1'b1)
                begin errors++; $display("FAIL cont_out[%0d] got=%h exp=%h", i, out_w, exp_out[i]); end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        checks++; if (cnt_a !== 8'd2 || cnt_b !== 8'd2)
            begin errors++; $display("FAIL cont_cnt got a=%0d b=%0d exp 2 2", cnt_a, cnt_b); end
    endtask

    task automatic test_backpressure();
        a = 4'h6; a_valid = 1'b1; b_valid = 1'b0; out_ready = 1'b1;
        tick();
        a_valid = 1'b0; b = 4'hD; b_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0)
                begin errors++; $display("FAIL bp_ready[%0d] got a=%b b=%b exp 0 0", i, a_ready, b_ready); end
            tick();
            checks++; if (out_w !== 4'h6 || out_valid !== 1'b1)
                begin errors++; $display("FAIL bp_hold[%0d] got=%h v=%b exp=6 v=1", i, out_w, out_valid); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (b_ready !== 1'b1 || a_ready !== 1'b0)
            begin errors++; $display("FAIL bp_release_ready got a=%b b=%b exp a=0 b=1", a_ready, b_ready); end
        tick();
        b_valid = 1'b0;
        checks++; if (out_w !== 4'hD || out_valid !== 1'b1)
            begin errors++; $display("FAIL bp_release_out got=%h v=%b exp=d v=1", out_w, out_valid); end
        checks++; if (cnt_a !== 8'd3 || cnt_b !== 8'd3)
            begin errors++; $display("FAIL bp_cnt got a=%0d b=%0d exp 3 3", cnt_a, cnt_b); end
    endtask

    task automatic test_drain();
        a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || out_w !== 4'hD)
            begin errors++; $display("FAIL drain got=%h v=%b exp=d v=0", out_w, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0 || cnt_b !== 8'd3)
            begin errors++; $display("FAIL drain_idle got v=%b cnt_b=%0d exp v=0 cnt_b=3", out_valid, cnt_b); end
    endtask

    task automatic test_wrap_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a = 4'(i); a_valid = 1'b1; b_valid = 1'b0; out_ready = 1'b1;
            tick();
        end
        checks++; if (cnt_a2 !== 2'd1) begin errors++; $display("FAIL wrap_cnt2 got=%0d exp=1", cnt_a2); end
        checks++; if (cnt_a !== 8'd5 || out_w !== 4'h4)
            begin errors++; $display("FAIL wrap_cnt8 got cnt=%0d out=%h exp 5 4", cnt_a, out_w); end
        a = 4'h7; b = 4'h8; a_valid = 1'b1; b_valid = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_w !== 4'h0)
            begin errors++; $display("FAIL midreset_out got=%h v=%b exp=0 v=0", out_w, out_valid); end
        checks++; if (cnt_a !== 8'd0 || cnt_b !== 8'd0 || cnt_a2 !== 2'd0)
            begin errors++; $display("FAIL midreset_cnt got a=%0d b=%0d a2=%0d exp 0 0 0", cnt_a, cnt_b, cnt_a2); end
        checks++; if (sel !== 1'b0 || a_ready !== 1'b1)
            begin errors++; $display("FAIL midreset_last got sel=%b ar=%b exp sel=0 ar=1", sel, a_ready); end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_solo_a();
        test_contention();
        test_backpressure();
        test_drain();
        test_wrap_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
